hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined core. It tracks in-flight register writes in a per-stage scoreboard, running from EX through WB, and produces:
- stall for the PC and IF/ID registers,
- bubble insertion into EX,
- IF/ID flush on a taken branch,
- registered forwarding selects for the EX operand muxes.

It also keeps saturating stall/flush event counters and a halt drain latch.

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/sb_match.sv | 28 ++
 rtl/hazard_scoreboard.sv | 121 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types, forward-select codes and helpers for the hazard scoreboard.
package hazard_pkg;

  // Widest register specifier a scoreboard slot can hold; narrower specifiers are zero-extended.
  localparam int unsigned RdMaxW = 8;

  localparam int unsigned FWD_RF   = 0;
  localparam int unsigned FWD_MEM  = 1;
  localparam int unsigned FWD_WB   = 2;
  localparam int unsigned FWD_HOLD = 3;  // WB-data latch code for the default DEPTH of 3

  typedef struct packed {
    logic              v;
    logic [RdMaxW-1:0] rd;
    logic              we;
    logic              ld;
  } slot_t;

  function automatic int unsigned clog2(input int unsigned val);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < val) r++;
    return r;
  endfunction

  // Forward select for a youngest match in slot k; the oldest slot reads the WB-data latch.
  function automatic int unsigned fwd_code(input int unsigned k, input int unsigned depth);
    if (k + 1 >= depth) return depth;
    if (k == 0) return FWD_MEM;
    if (k == 1) return FWD_WB;
    return k + 1;
  endfunction

endpackage

// File: rtl/sb_match.sv
// Youngest-match lookup of one source register against the scoreboard slots.
module sb_match import hazard_pkg::*; #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned IDX_W = 2
) (
  input  slot_t             slots_i [DEPTH],
  input  logic [RdMaxW-1:0] src_i,
  input  logic              used_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              ld_o
);

  // Scan oldest to youngest so the lowest matching index is the one left standing.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    ld_o  = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (used_i && slots_i[i].v && slots_i[i].we && (slots_i[i].rd == src_i)) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
        ld_o  = slots_i[i].ld;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: in-flight write scoreboard, stall/bubble/flush, fwd selects.
// Define HAZARD_FWD_EN for the forwarding build; without it every RAW hazard stalls.
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int unsigned REG_BITS   = 3,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_BITS-1:0]       id_rs1,
  input  logic                      id_rs1_used,
  input  logic [REG_BITS-1:0]       id_rs2,
  input  logic                      id_rs2_used,
  input  logic [REG_BITS-1:0]       id_rd,
  input  logic                      id_rd_we,
  input  logic                      id_is_load,
  input  logic                      ex_bt,
  input  logic                      id_halt,
  output logic                      stall,
  output logic                      bubble_ex,
  output logic                      flush_ifid,
  output logic [clog2(DEPTH+1)-1:0] fwd_a,
  output logic [clog2(DEPTH+1)-1:0] fwd_b,
  output logic                      halted,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  localparam int unsigned FwdW = clog2(DEPTH + 1);

  slot_t            slot_q [DEPTH];
  slot_t            slot_d [DEPTH];
  logic [FwdW-1:0]  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             hit_a, hit_b, ld_a, ld_b;
  logic [FwdW-1:0]  idx_a, idx_b, code_a, code_b;
  logic             hazard, issue;

  sb_match #(.DEPTH(DEPTH), .IDX_W(FwdW)) u_match_a (
    .slots_i (slot_q),
    .src_i   (RdMaxW'(id_rs1)),
    .used_i  (id_rs1_used),
    .hit_o   (hit_a),
    .idx_o   (idx_a),
    .ld_o    (ld_a)
  );

  sb_match #(.DEPTH(DEPTH), .IDX_W(FwdW)) u_match_b (
    .slots_i (slot_q),
    .src_i   (RdMaxW'(id_rs2)),
    .used_i  (id_rs2_used),
    .hit_o   (hit_b),
    .idx_o   (idx_b),
    .ld_o    (ld_b)
  );

`ifdef HAZARD_FWD_EN
  // Only a load too young to have its data yet forces a stall; everything else forwards.
  assign hazard = (hit_a && ld_a && (32'(idx_a) < LOAD_STALL)) ||
                  (hit_b && ld_b && (32'(idx_b) < LOAD_STALL));
  assign code_a = FwdW'(fwd_code(32'(idx_a), DEPTH));
  assign code_b = FwdW'(fwd_code(32'(idx_b), DEPTH));
`else
  logic unused_match;
  assign hazard       = hit_a || hit_b;
  assign code_a       = FwdW'(FWD_RF);
  assign code_b       = FwdW'(FWD_RF);
  assign unused_match = ^{ld_a, ld_b, idx_a, idx_b, 32'(LOAD_STALL)};
`endif

  always_comb begin
    // A taken branch kills the ID instruction, so it overrides any stall.
    stall      = !ex_bt && (halted_q || (id_valid && hazard));
    flush_ifid = ex_bt;
    bubble_ex  = stall || flush_ifid || halted_q;
    issue      = id_valid && !stall && !flush_ifid && !halted_q;

    slot_d[0] = '0;
    if (issue) begin
      slot_d[0] = '{v: 1'b1, rd: RdMaxW'(id_rd), we: id_rd_we, ld: id_is_load};
    end
    for (int i = 1; i < int'(DEPTH); i++) slot_d[i] = slot_q[i-1];

    fwd_a_d  = (issue && hit_a) ? code_a : FwdW'(FWD_RF);
    fwd_b_d  = (issue && hit_b) ? code_b : FwdW'(FWD_RF);
    halted_d = halted_q || (id_halt && issue);

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (flush_ifid && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= '0;
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      slot_q      <= slot_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic vs a
// history-based model of issued instructions. Honours HAZARD_FWD_EN like the design.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int DEPTH      = 3;
  localparam int LOAD_STALL = 1;
`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef struct packed {
    logic v; logic [2:0] rs1; logic u1; logic [2:0] rs2; logic u2;
    logic [2:0] rd; logic we; logic ld; logic halt; logic bt;
  } instr_t;
  typedef struct { logic [2:0] rd; logic ld; int t; } rec_t;
  localparam instr_t NOP = '0;

  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 0, id_rs1_used = 0, id_rs2_used = 0, id_rd_we = 0, id_is_load = 0;
  logic ex_bt = 0, id_halt = 0;
  logic [2:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic stall, bubble_ex, flush_ifid, halted, stall4, bubble4, flush4, halted4;
  logic [1:0] fwd_a, fwd_b, fwd_a4, fwd_b4;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0] stall_cnt4, flush_cnt4;
  int tests = 0, failures = 0;

  // Model state: issue history plus the architecturally visible registers.
  rec_t hist [$];
  int cyc = 0;
  logic m_halted = 0;
  logic [1:0] m_fwd_a = 0, m_fwd_b = 0;
  int m_sc = 0, m_fc = 0, m_sc4 = 0, m_fc4 = 0;
  logic e_stall, e_flush, e_bubble, e_issue;
  logic [1:0] e_code_a, e_code_b;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_BITS(3), .DEPTH(DEPTH), .LOAD_STALL(LOAD_STALL), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .ex_bt(ex_bt), .id_halt(id_halt), .stall(stall),
    .bubble_ex(bubble_ex), .flush_ifid(flush_ifid), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_scoreboard #(.REG_BITS(3), .DEPTH(DEPTH), .LOAD_STALL(LOAD_STALL), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .ex_bt(ex_bt), .id_halt(id_halt), .stall(stall4),
    .bubble_ex(bubble4), .flush_ifid(flush4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
    .halted(halted4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  function automatic instr_t mk(logic v, logic [2:0] rd, logic we, logic ld,
                                logic [2:0] rs1, logic u1, logic [2:0] rs2, logic u2);
    instr_t r;
    r = '{v: v, rs1: rs1, u1: u1, rs2: rs2, u2: u2, rd: rd, we: we, ld: ld,
          halt: 1'b0, bt: 1'b0};
    return r;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t r;
    r.v    = ($urandom_range(0, 3) != 0);
    r.rs1  = 3'($urandom_range(0, 3));
    r.u1   = 1'($urandom);
    r.rs2  = 3'($urandom_range(0, 3));
    r.u2   = 1'($urandom);
    r.rd   = 3'($urandom_range(0, 3));
    r.we   = ($urandom_range(0, 3) != 0);
    r.ld   = r.we && ($urandom_range(0, 2) == 0);
    r.halt = 1'b0;
    r.bt   = ($urandom_range(0, 7) == 0);
    return r;
  endfunction

  function automatic logic [55:0] obs();
    return {stall, bubble_ex, flush_ifid, fwd_a, fwd_b, halted, stall_cnt, flush_cnt,
            stall4, bubble4, flush4, fwd_a4, fwd_b4, halted4, stall_cnt4, flush_cnt4};
  endfunction

  function automatic logic [55:0] expv();
    logic [7:0] e8;
    e8 = {e_stall, e_bubble, e_flush, m_fwd_a, m_fwd_b, m_halted};
    return {e8, 16'(m_sc), 16'(m_fc), e8, 4'(m_sc4), 4'(m_fc4)};
  endfunction

  task automatic apply(input instr_t i);
    id_valid = i.v; id_rs1 = i.rs1; id_rs1_used = i.u1; id_rs2 = i.rs2; id_rs2_used = i.u2;
    id_rd = i.rd; id_rd_we = i.we; id_is_load = i.ld; id_halt = i.halt; ex_bt = i.bt;
  endtask

  // Age of the most recently issued live writer of src (-1 if none).
  task automatic find(input logic used, input logic [2:0] src, output int age, output logic ld);
    age = -1;
    ld  = 1'b0;
    if (!used) return;
    for (int j = hist.size() - 1; j >= 0; j--) begin
      if (hist[j].rd == src) begin
        age = cyc - hist[j].t - 1;
        ld  = hist[j].ld;
        return;
      end
    end
  endtask

  task automatic model_eval();
    int aa, ab;
    logic la, lb, haz_fwd, haz_all;
    find(id_rs1_used, id_rs1, aa, la);
    find(id_rs2_used, id_rs2, ab, lb);
    haz_fwd  = (aa >= 0 && la && aa < LOAD_STALL) || (ab >= 0 && lb && ab < LOAD_STALL);
    haz_all  = (aa >= 0) || (ab >= 0);
    e_stall  = !ex_bt && (m_halted || (id_valid && (FWD_EN ? haz_fwd : haz_all)));
    e_flush  = ex_bt;
    e_bubble = e_stall || e_flush || m_halted;
    e_issue  = id_valid && !e_stall && !ex_bt && !m_halted;
    e_code_a = 2'd0;
    e_code_b = 2'd0;
    if (FWD_EN && e_issue && aa >= 0) e_code_a = (aa < DEPTH - 1) ? 2'(aa + 1) : 2'(DEPTH);
    if (FWD_EN && e_issue && ab >= 0) e_code_b = (ab < DEPTH - 1) ? 2'(ab + 1) : 2'(DEPTH);
  endtask

  task automatic model_commit();
    if (e_issue && id_rd_we) hist.push_back('{rd: id_rd, ld: id_is_load, t: cyc});
    m_fwd_a = e_code_a;
    m_fwd_b = e_code_b;
    if (id_halt && e_issue) m_halted = 1'b1;
    if (e_stall && m_sc < 65535) m_sc++;
    if (e_stall && m_sc4 < 15) m_sc4++;
    if (e_flush && m_fc < 65535) m_fc++;
    if (e_flush && m_fc4 < 15) m_fc4++;
    cyc++;
    while (hist.size() > 0 && cyc - hist[0].t - 1 >= DEPTH) void'(hist.pop_front());
  endtask

  task automatic model_reset();
    hist.delete();
    m_halted = 1'b0; m_fwd_a = 2'd0; m_fwd_b = 2'd0;
    m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_commit();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(NOP); #1; model_eval(); tick();
    end
  endtask

  task automatic test_reset();
    instr_t r;
    @(negedge clk);
    r = rnd_instr(); r.v = 1'b1; r.u1 = 1'b1; r.u2 = 1'b1; r.bt = 1'b0;
    apply(r); #1;
    model_reset();
    tests++;
    if (obs() !== 56'h0) begin
      failures++; $display("FAIL reset got=%h want=0", obs());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fwd_alu();
    instr_t prog [$];
    int pc = 0, n = 0, stalls = 0;
    logic [1:0] cap = 2'b11;
    prog = '{mk(1, 3'd3, 1, 0, 3'd0, 0, 3'd0, 0), mk(1, 3'd4, 1, 0, 3'd3, 1, 3'd1, 0), NOP};
    idle(DEPTH);
    while (pc < prog.size() && n < 16) begin
      apply(prog[pc]); #1; model_eval();
      tests++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL fwd_alu n=%0d got=%h want=%h", n, obs(), expv());
      end
      if (stall) stalls++;
      if (pc == 2) cap = fwd_a;
      if (e_issue || !prog[pc].v || prog[pc].bt) pc++;
      tick(); n++;
    end
    tests++;
    if (pc != 3 || stalls != (FWD_EN ? 0 : 3) || cap !== (FWD_EN ? 2'(FWD_MEM) : 2'(FWD_RF))) begin
      failures++;
      $display("FAIL fwd_alu_seq pc=%0d stalls=%0d fwd_a=%0d want pc=3 stalls=%0d fwd_a=%0d",
               pc, stalls, cap, FWD_EN ? 0 : 3, FWD_EN ? FWD_MEM : FWD_RF);
    end
  endtask

  task automatic test_load_use();
    instr_t prog [$];
    int pc = 0, n = 0;
    logic [15:0] sc0;
    logic [1:0] cap = 2'b11;
    prog = '{mk(1, 3'd2, 1, 1, 3'd0, 0, 3'd0, 0), mk(1, 3'd1, 1, 0, 3'd1, 1, 3'd2, 1), NOP};
    idle(DEPTH);
    sc0 = stall_cnt;
    while (pc < prog.size() && n < 16) begin
      apply(prog[pc]); #1; model_eval();
      tests++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL load_use n=%0d got=%h want=%h", n, obs(), expv());
      end
      if (pc == 2) cap = fwd_b;
      if (e_issue || !prog[pc].v || prog[pc].bt) pc++;
      tick(); n++;
    end
    tests++;
    if (pc != 3 || (stall_cnt - sc0) != (FWD_EN ? 16'd1 : 16'd3) ||
        cap !== (FWD_EN ? 2'(FWD_WB) : 2'(FWD_RF))) begin
      failures++;
      $display("FAIL load_use_seq pc=%0d stalls=%0d fwd_b=%0d want pc=3 stalls=%0d fwd_b=%0d",
               pc, stall_cnt - sc0, cap, FWD_EN ? 1 : 3, FWD_EN ? FWD_WB : FWD_RF);
    end
  endtask

  task automatic test_hold_youngest();
    instr_t prog [$];
    int pc = 0, n = 0, stalls = 0;
    logic [1:0] cap_b = 2'b11, cap_a = 2'b11;
    prog = '{mk(1, 3'd5, 1, 0, 3'd0, 0, 3'd0, 0), mk(1, 3'd6, 1, 0, 3'd0, 1, 3'd1, 1),
             mk(1, 3'd7, 1, 0, 3'd1, 1, 3'd0, 0), mk(1, 3'd0, 1, 0, 3'd0, 0, 3'd5, 1), NOP,
             mk(1, 3'd5, 1, 0, 3'd0, 0, 3'd0, 0), mk(1, 3'd5, 1, 0, 3'd0, 0, 3'd0, 0),
             mk(1, 3'd1, 1, 0, 3'd5, 1, 3'd0, 0), NOP};
    idle(DEPTH);
    while (pc < prog.size() && n < 32) begin
      apply(prog[pc]); #1; model_eval();
      tests++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL hold_youngest n=%0d got=%h want=%h", n, obs(), expv());
      end
      if (stall) stalls++;
      if (pc == 4) cap_b = fwd_b;
      if (pc == 8) cap_a = fwd_a;
      if (e_issue || !prog[pc].v || prog[pc].bt) pc++;
      tick(); n++;
    end
    tests++;
    if (pc != 9 || stalls != (FWD_EN ? 0 : 4) ||
        cap_b !== (FWD_EN ? 2'(FWD_HOLD) : 2'(FWD_RF)) ||
        cap_a !== (FWD_EN ? 2'(FWD_MEM) : 2'(FWD_RF))) begin
      failures++;
      $display("FAIL hold_seq pc=%0d stalls=%0d fwd_b=%0d fwd_a=%0d want stalls=%0d",
               pc, stalls, cap_b, cap_a, FWD_EN ? 0 : 4);
    end
  endtask

  task automatic test_flush();
    instr_t prog [$];
    instr_t add_bt;
    int pc = 0, n = 0;
    logic [15:0] fc0;
    logic [2:0] cap_ctl = 3'b111;
    logic [1:0] cap = 2'b11;
    add_bt = mk(1, 3'd1, 1, 0, 3'd1, 0, 3'd2, 1);
    add_bt.bt = 1'b1;
    prog = '{mk(1, 3'd2, 1, 1, 3'd0, 0, 3'd0, 0), add_bt, mk(1, 3'd4, 1, 0, 3'd1, 1, 3'd0, 0),
             NOP};
    idle(DEPTH);
    fc0 = flush_cnt;
    while (pc < prog.size() && n < 16) begin
      apply(prog[pc]); #1; model_eval();
      tests++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL flush n=%0d got=%h want=%h", n, obs(), expv());
      end
      if (pc == 1) cap_ctl = {stall, flush_ifid, bubble_ex};
      if (pc == 3) cap = fwd_a;
      if (e_issue || !prog[pc].v || prog[pc].bt) pc++;
      tick(); n++;
    end
    tests++;
    if (pc != 4 || cap_ctl !== 3'b011 || cap !== 2'(FWD_RF) || (flush_cnt - fc0) != 16'd1) begin
      failures++;
      $display("FAIL flush_seq pc=%0d ctl=%b fwd_a=%0d flushes=%0d want ctl=011 fwd_a=0 flushes=1",
               pc, cap_ctl, cap, flush_cnt - fc0);
    end
  endtask

  task automatic test_random(input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      apply(rnd_instr()); #1; model_eval();
      tests++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL random n=%0d got=%h want=%h", n, obs(), expv());
      end
      tick();
    end
  endtask

  task automatic test_halt();
    instr_t r;
    idle(DEPTH);
    for (int n = 0; n < 22; n++) begin
      if (n == 0) begin
        r = mk(1, 3'd2, 0, 0, 3'd0, 0, 3'd0, 0); r.halt = 1'b1; r.bt = 1'b1;
      end else if (n == 1) begin
        r = mk(1, 3'd0, 0, 0, 3'd0, 0, 3'd0, 0); r.halt = 1'b1;
      end else begin
        r = rnd_instr(); r.halt = 1'($urandom);
      end
      apply(r); #1; model_eval();
      tests++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL halt n=%0d got=%h want=%h", n, obs(), expv());
      end
      tick();
    end
    apply(NOP); #1;
    tests++;
    if ({halted, stall, bubble_ex, stall_cnt4} !== {3'b111, 4'hF}) begin
      failures++;
      $display("FAIL halt_hold halted=%b stall=%b bubble=%b cnt4=%0d want 1 1 1 15",
               halted, stall, bubble_ex, stall_cnt4);
    end
    model_eval(); tick();
  endtask

  task automatic test_reset_mid();
    instr_t r;
    r = rnd_instr(); r.v = 1'b1; r.u1 = 1'b1; r.u2 = 1'b1; r.bt = 1'b0;
    apply(r);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (obs() !== 56'h0) begin
      failures++; $display("FAIL reset_mid got=%h want=0", obs());
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    test_random(20);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_hold_youngest();
    test_flush();
    test_random(400);
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
